// File: rtl/uram_arb_pkg.sv
// Shared types for the UltraRAM port arbiter: port ids, FSM states,
// the read-response tag carried through the latency pipe, and the latency helper.
package uram_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic  vld;
    port_e port;
  } rsp_tag_t;

  // URAM read latency: the macro's internal registers plus the output pipeline.
  function automatic int rlat(input int nbpipe);
    return nbpipe + 2;
  endfunction

endpackage

// File: rtl/uram_port_arbiter_if.sv
// One requester's memory port: request handshake plus a pulsed,
// non-backpressured read response.
interface uram_port_arbiter_if #(
  parameter int AWIDTH  = 12,
  parameter int NUM_COL = 9,
  parameter int DWIDTH  = 72
);
  logic               req_vld;
  logic               req_rdy;
  logic [NUM_COL-1:0] req_we;
  logic [AWIDTH-1:0]  req_addr;
  logic [DWIDTH-1:0]  req_wdata;
  logic               rsp_vld;
  logic [DWIDTH-1:0]  rsp_data;

  modport master (
    output req_vld, req_we, req_addr, req_wdata,
    input  req_rdy, rsp_vld, rsp_data
  );

  modport slave (
    input  req_vld, req_we, req_addr, req_wdata,
    output req_rdy, rsp_vld, rsp_data
  );
endinterface

// File: rtl/uram_rsp_tag_pipe.sv
// Shift register of {vld, port} tags that follows each read through the
// macro latency so the returning data can be steered to its issuer.
module uram_rsp_tag_pipe
  import uram_arb_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic     clk,
  input  logic     rst,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t pipe [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking would collapse the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '{vld: 1'b0, port: PORT_A};
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/uram_port_arbiter.sv
// Shares one single-port no-change URAM between two requesters: zero-fills the
// array after reset, then grants one op per cycle round-robin and returns reads.
module uram_port_arbiter
  import uram_arb_pkg::*;
#(
  parameter int AWIDTH  = 12,
  parameter int NUM_COL = 9,
  parameter int CWIDTH  = 8,
  parameter int DWIDTH  = NUM_COL * CWIDTH,
  parameter int NBPIPE  = 3
) (
  input  logic               clk,
  input  logic               rst,
  uram_port_arbiter_if.slave a,
  uram_port_arbiter_if.slave b,
  output logic               init_done,
  output logic               ram_en,
  output logic [NUM_COL-1:0] ram_we,
  output logic [AWIDTH-1:0]  ram_addr,
  output logic [DWIDTH-1:0]  ram_din,
  output logic               ram_regce,
  input  logic [DWIDTH-1:0]  ram_dout
);

  localparam int RLAT = rlat(NBPIPE);

  state_e            state, state_nx;
  logic [AWIDTH-1:0] init_cnt, init_cnt_nx;
  port_e             ptr, ptr_nx;
  logic              gnt_a, gnt_b;
  rsp_tag_t          tag_in, tag_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      ptr      <= PORT_A;
    end else begin
      state    <= state_nx;
      init_cnt <= init_cnt_nx;
      ptr      <= ptr_nx;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    ptr_nx      = ptr;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    init_done   = 1'b0;
    ram_en      = 1'b0;
    ram_we      = '0;
    ram_addr    = '0;
    ram_din     = '0;
    tag_in      = '{vld: 1'b0, port: PORT_A};

    // Outputs are forced idle while rst is held, not just after its edge.
    if (!rst) begin
      unique case (state)
        ST_INIT: begin
          ram_en   = 1'b1;
          ram_we   = '1;
          ram_addr = init_cnt;
          if (init_cnt == '1) state_nx = ST_RUN;
          else                init_cnt_nx = init_cnt + 1'b1;
        end
        ST_RUN: begin
          init_done = 1'b1;
          gnt_a     = a.req_vld & (~b.req_vld | (ptr == PORT_A));
          gnt_b     = b.req_vld & ~gnt_a;
          if (a.req_vld && b.req_vld) ptr_nx = (ptr == PORT_A) ? PORT_B : PORT_A;
          if (gnt_a) begin
            ram_en   = 1'b1;
            ram_we   = a.req_we;
            ram_addr = a.req_addr;
            ram_din  = a.req_wdata;
            tag_in   = '{vld: ~|a.req_we, port: PORT_A};
          end else if (gnt_b) begin
            ram_en   = 1'b1;
            ram_we   = b.req_we;
            ram_addr = b.req_addr;
            ram_din  = b.req_wdata;
            tag_in   = '{vld: ~|b.req_we, port: PORT_B};
          end
        end
        default: state_nx = ST_INIT;
      endcase
    end
  end

  uram_rsp_tag_pipe #(.DEPTH(RLAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign a.req_rdy  = gnt_a;
  assign b.req_rdy  = gnt_b;
  assign a.rsp_vld  = ~rst & tag_out.vld & (tag_out.port == PORT_A);
  assign b.rsp_vld  = ~rst & tag_out.vld & (tag_out.port == PORT_B);
  assign a.rsp_data = ram_dout;
  assign b.rsp_data = ram_dout;
  assign ram_regce  = 1'b1;

endmodule

// File: tb/tb_uram_port_arbiter.sv
// Randomised bench for uram_port_arbiter against a behavioural URAM and a
// cycle-level reference of the arbitration, zero-fill and response timing.
module tb_uram_port_arbiter;

  localparam int AW    = 4;
  localparam int NC    = 9;
  localparam int CW    = 8;
  localparam int DW    = NC * CW;
  localparam int NBP   = 3;
  localparam int RL    = NBP + 2;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done, ram_en, ram_regce;
  logic [NC-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  uram_port_arbiter_if #(.AWIDTH(AW), .NUM_COL(NC), .DWIDTH(DW)) a_if ();
  uram_port_arbiter_if #(.AWIDTH(AW), .NUM_COL(NC), .DWIDTH(DW)) b_if ();

  uram_port_arbiter #(
    .AWIDTH(AW), .NUM_COL(NC), .CWIDTH(CW), .DWIDTH(DW), .NBPIPE(NBP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a_if.slave),
    .b         (b_if.slave),
    .init_done (init_done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_regce (ram_regce),
    .ram_dout  (ram_dout)
  );

  // Behavioural no-change URAM; junk_fill seeds garbage so the zero-fill matters.
  logic [DW-1:0] uram  [WORDS];
  logic [DW-1:0] upipe [RL];
  bit            junk_fill;

  always @(posedge clk) begin
    if (junk_fill) begin
      for (int i = 0; i < WORDS; i++) uram[i] <= {$urandom, $urandom, 8'(i + 1)};
    end else if (ram_en && |ram_we) begin
      for (int i = 0; i < NC; i++)
        if (ram_we[i]) uram[ram_addr][i*CW +: CW] <= ram_din[i*CW +: CW];
    end
    if (ram_en && !(|ram_we)) upipe[0] <= uram[ram_addr];
    for (int i = 1; i < RL; i++) upipe[i] <= upipe[i-1];
  end
  assign ram_dout = upipe[RL-1];

  // Reference model state
  typedef struct {
    int            due;
    bit            port_b;
    logic [DW-1:0] data;
  } exp_t;

  logic [DW-1:0] ref_mem [WORDS];
  exp_t          pend [$];
  bit            in_init, ptr_b, last_ga, last_gb;
  int            init_idx, cyc, total, bad;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input bit pb, input bit vld, input logic [NC-1:0] we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] d);
    if (pb) begin
      b_if.req_vld = vld; b_if.req_we = we; b_if.req_addr = addr; b_if.req_wdata = d;
    end else begin
      a_if.req_vld = vld; a_if.req_we = we; a_if.req_addr = addr; a_if.req_wdata = d;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic step();
    bit            ga, gb, eva, evb;
    logic [NC-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    ga = 1'b0; gb = 1'b0;
    #1;
    if (rst) begin
      check("rst_a_rdy", a_if.req_rdy, 0);
      check("rst_b_rdy", b_if.req_rdy, 0);
      check("rst_init_done", init_done, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
    end else if (in_init) begin
      check("init_ram_en", ram_en, 1);
      check("init_ram_we", ram_we, {NC{1'b1}});
      check("init_ram_addr", ram_addr, init_idx);
      check("init_ram_din", ram_din, 0);
      check("init_a_rdy", a_if.req_rdy, 0);
      check("init_b_rdy", b_if.req_rdy, 0);
      check("init_done_low", init_done, 0);
    end else begin
      ga = a_if.req_vld && (!b_if.req_vld || !ptr_b);
      gb = b_if.req_vld && !ga;
      check("init_done_high", init_done, 1);
      check("a_rdy", a_if.req_rdy, ga);
      check("b_rdy", b_if.req_rdy, gb);
      check("ram_en", ram_en, ga | gb);
      if (ga || gb) begin
        we   = ga ? a_if.req_we    : b_if.req_we;
        addr = ga ? a_if.req_addr  : b_if.req_addr;
        d    = ga ? a_if.req_wdata : b_if.req_wdata;
        check("ram_addr", ram_addr, addr);
        check("ram_we", ram_we, we);
        if (|we) check("ram_din", ram_din, d);
      end
    end
    eva = 1'b0; evb = 1'b0;
    if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].port_b) evb = 1'b1;
      else                eva = 1'b1;
    end
    check("a_rsp_vld", a_if.rsp_vld, eva);
    check("b_rsp_vld", b_if.rsp_vld, evb);
    if (eva) check("a_rsp_data", a_if.rsp_data, pend[0].data);
    if (evb) check("b_rsp_data", b_if.rsp_data, pend[0].data);
    if (eva || evb) void'(pend.pop_front());

    @(posedge clk);
    cyc++;
    last_ga = ga;
    last_gb = gb;
    if (rst) begin
      in_init = 1'b1; init_idx = 0; ptr_b = 1'b0;
      pend.delete();
    end else if (in_init) begin
      init_idx++;
      if (init_idx == WORDS) begin
        in_init = 1'b0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
      end
    end else begin
      if (a_if.req_vld && b_if.req_vld) ptr_b = !ptr_b;
      if (ga || gb) begin
        if (we == '0) pend.push_back('{due: cyc - 1 + RL, port_b: gb, data: ref_mem[addr]});
        else
          for (int i = 0; i < NC; i++)
            if (we[i]) ref_mem[addr][i*CW +: CW] = d[i*CW +: CW];
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (RL + 2) step();
  endtask

  // Single-port op; the grant must come within a bounded number of cycles.
  task automatic single_op(input bit pb, input logic [NC-1:0] we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] d);
    int n;
    n = 0;
    drive(pb, 1'b1, we, addr, d);
    do begin
      step();
      n++;
    end while (!(pb ? last_gb : last_ga) && n < 40);
    if (!(pb ? last_gb : last_ga)) check("op_grant_timeout", 0, 1);
    drive(pb, 1'b0, '0, '0, '0);
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, 8'($urandom)};
  endfunction

  initial begin
    bit            hold_a, hold_b;
    int            ia, ib, n;
    logic [NC-1:0] rwe;
    in_init = 1'b1; init_idx = 0; ptr_b = 1'b0; cyc = 0; total = 0; bad = 0;
    last_ga = 1'b0; last_gb = 1'b0;
    idle();
    rst = 1'b1;
    junk_fill = 1'b1;
    @(negedge clk);
    step();
    junk_fill = 1'b0;
    step();
    rst = 1'b0;

    // Zero-fill, then read every word back from port A.
    repeat (WORDS) step();
    step();
    for (int i = 0; i < WORDS; i++) single_op(1'b0, '0, AW'(i), '0);
    drain();

    // Full write then read on A.
    single_op(1'b0, 9'h1FF, 4'd3, 72'h11_2233_4455_6677_8899);
    single_op(1'b0, '0, 4'd3, '0);
    drain();

    // Distinct data, then both ports contend for six reads.
    for (int i = 6; i < 12; i++) single_op(1'b0, 9'h1FF, AW'(i), rand_word());
    ia = 6; ib = 9; n = 0;
    while ((ia < 9 || ib < 12) && n < 40) begin
      drive(1'b0, ia < 9, '0, AW'(ia), '0);
      drive(1'b1, ib < 12, '0, AW'(ib), '0);
      step();
      n++;
      if (last_ga) ia++;
      if (last_gb) ib++;
    end
    if (ia < 9 || ib < 12) check("contend_timeout", 0, 1);
    drain();

    // Single-lane write into a zeroed word.
    single_op(1'b0, 9'h001, 4'd5, {64'hDEAD_BEEF_CAFE_F00D, 8'hAB});
    single_op(1'b1, '0, 4'd5, '0);
    drain();

    // Random traffic from both ports; unserved requests are held.
    hold_a = 1'b0; hold_b = 1'b0;
    repeat (300) begin
      if (!hold_a) begin
        rwe = ($urandom_range(0, 1) == 0) ? '0 : NC'($urandom);
        drive(1'b0, $urandom_range(0, 2) != 0, rwe, AW'($urandom), rand_word());
      end
      if (!hold_b) begin
        rwe = ($urandom_range(0, 1) == 0) ? '0 : NC'($urandom);
        drive(1'b1, $urandom_range(0, 2) != 0, rwe, AW'($urandom), rand_word());
      end
      step();
      hold_a = a_if.req_vld && !last_ga;
      hold_b = b_if.req_vld && !last_gb;
    end
    drain();

    // Reset with three reads in flight, requests held through the new zero-fill.
    for (int i = 0; i < 3; i++) single_op(1'b0, '0, AW'(i + 6), '0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 1'b1, '0, 4'd7, '0);
    drive(1'b1, 1'b1, '0, 4'd8, '0);
    hold_a = 1'b1; hold_b = 1'b1; n = 0;
    while ((hold_a || hold_b) && n < WORDS + 10) begin
      step();
      n++;
      if (last_ga) begin hold_a = 1'b0; drive(1'b0, 1'b0, '0, '0, '0); end
      if (last_gb) begin hold_b = 1'b0; drive(1'b1, 1'b0, '0, '0, '0); end
    end
    if (hold_a || hold_b) check("post_rst_grant_timeout", 0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
